// File: rtl/dpm_ccgen.sv
// Condition-code generator: reduces ALU write-bus flags to N/Z/V/C per data size and holds the UCC, PCC and overflow-trap state.
// Latency: one lck_l edge from op presented to registered outputs, with no forwarding.
// Backpressure: stall_h freezes UCC, PCC and trap set; trap_ack_h is still honoured while stalled.
module dpm_ccgen (
    input  logic        lck_l,
    input  logic        rst_h,
    input  logic [31:0] wbus_h,
    input  logic [3:0]  wmuxz_h,
    input  logic [3:0]  aluv_h,
    input  logic [3:0]  cout_h,
    input  logic [1:0]  d_size_h,
    input  logic [2:0]  cc_op_h,
    input  logic        c_inv_h,
    input  logic        zacc_h,
    input  logic        stall_h,
    input  logic        iv_en_h,
    input  logic        trap_ack_h,
    output logic [3:0]  ucc_h,
    output logic [3:0]  pcc_h,
    output logic        cyin_h,
    output logic        ovf_trap_h
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_UCC   = 3'b001;
    localparam logic [2:0] OP_XFER  = 3'b010;
    localparam logic [2:0] OP_BOTH  = 3'b011;
    localparam logic [2:0] OP_CLR   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_MOVE  = 3'b110;
    localparam logic [2:0] OP_ARITH = 3'b111;

    logic [3:0] ucc_q;
    logic [3:0] pcc_q;
    logic       trap_q;

    logic [1:0] k;
    logic [4:0] n_idx;
    logic       nc;
    logic       zc_raw;
    logic       vc;
    logic       cc;
    logic       ucc_zc;
    logic       pcc_zc;
    logic       v_set;

    always_comb begin
        case (d_size_h)
            2'b00:   k = 2'd0;
            2'b01:   k = 2'd1;
            default: k = 2'd3;
        endcase
        n_idx = {k, 3'b111};
        nc    = wbus_h[n_idx];
        case (k)
            2'd0:    zc_raw = wmuxz_h[0];
            2'd1:    zc_raw = &wmuxz_h[1:0];
            default: zc_raw = &wmuxz_h;
        endcase
        vc = aluv_h[k];
        cc = cout_h[k] ^ c_inv_h;
        // Z accumulation always folds in the old Z of the register being written.
        ucc_zc = zc_raw & (~zacc_h | ucc_q[2]);
        pcc_zc = zc_raw & (~zacc_h | pcc_q[2]);
        v_set  = 1'b0;
        if (iv_en_h) begin
            case (cc_op_h)
                OP_BOTH, OP_ARITH: v_set = vc;
                OP_LOAD:           v_set = wbus_h[1];
                default:           v_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge lck_l) begin
        if (rst_h) begin
            ucc_q  <= 4'b0000;
            pcc_q  <= 4'b0000;
            trap_q <= 1'b0;
        end else begin
            if (!stall_h) begin
                case (cc_op_h)
                    OP_HOLD:  ;
                    OP_UCC:   ucc_q <= {nc, ucc_zc, vc, cc};
                    OP_XFER:  pcc_q <= ucc_q;
                    OP_BOTH: begin
                        ucc_q <= {nc, ucc_zc, vc, cc};
                        pcc_q <= {nc, pcc_zc, vc, cc};
                    end
                    OP_CLR:   pcc_q <= 4'b0000;
                    OP_LOAD:  pcc_q <= wbus_h[3:0];
                    OP_MOVE:  pcc_q <= {nc, pcc_zc, 1'b0, pcc_q[0]};
                    OP_ARITH: pcc_q <= {nc, pcc_zc, vc, pcc_q[0]};
                    default:  ;
                endcase
            end
            // A new V=1 write beats a coincident acknowledge.
            if (!stall_h && v_set)
                trap_q <= 1'b1;
            else if (trap_ack_h)
                trap_q <= 1'b0;
        end
    end

    assign ucc_h      = ucc_q;
    assign pcc_h      = pcc_q;
    assign cyin_h     = ucc_q[0];
    assign ovf_trap_h = trap_q;

endmodule

// File: doc/dpm_ccgen.md
Name: dpm_ccgen

Overview:
- Condition-code generator directly downstream of the 32-bit ALP array in the DPM datapath.
- Consumes the ALU write bus, per-byte zero/overflow flags and per-byte carry-outs, and reduces them to N/Z/V/C for the current data size.
- Keeps a microcode flag register (UCC) and the architectural PSL condition codes (PCC).
- Supplies the carry for multi-precision operations and raises an integer-overflow trap request with a request/acknowledge handshake.

Parameters:
- none (datapath fixed at 32 bits, 4 byte lanes)

Ports:
- lck_l  in  1  clock; all state updates on rising edge
- rst_h  in  1  synchronous reset, active-high
- wbus_h  in  32  ALU write bus result
- wmuxz_h  in  4  per-byte zero flags, 1 = byte is zero
- aluv_h  in  4  per-byte signed overflow at byte MSB
- cout_h  in  4  per-byte carry-out at byte MSB
- d_size_h  in  2  00 byte, 01 word, 10/11 longword
- cc_op_h  in  3  flag update opcode (see Behaviour)
- c_inv_h  in  1  invert carry before use (subtract borrow convention)
- zacc_h  in  1  Z accumulate: new Z = computed Z AND old Z
- stall_h  in  1  freeze all state
- iv_en_h  in  1  PSL IV, integer overflow trap enable
- trap_ack_h  in  1  trap request acknowledge
- ucc_h  out  4  UCC {N,Z,V,C}
- pcc_h  out  4  PCC {N,Z,V,C}
- cyin_h  out  1  UCC.C, carry into next precision step
- ovf_trap_h  out  1  integer overflow trap request

Behaviour:
- Reset: ucc_h = 0000, pcc_h = 0000, ovf_trap_h = 0. Reset overrides stall_h and all other inputs.
- Size index k: byte 0, word 1, long 3.
- Computed flags (combinational, same-cycle inputs):
  - Nc = wbus_h[8k+7]
  - Zc = AND of wmuxz_h[0..k]; if zacc_h, AND-ed with the old Z of the destination register
  - Vc = aluv_h[k]
  - Cc = cout_h[k] XOR c_inv_h
- Bytes above k are ignored.
- cc_op_h (effective when stall_h = 0):
  - 000 hold
  - 001 UCC <= computed
  - 010 PCC <= UCC
  - 011 UCC and PCC <= computed; PCC zacc uses old PCC.Z
  - 100 PCC <= 0000
  - 101 PCC <= wbus_h[3:0] (N=bit3, Z=bit2, V=bit1, C=bit0)
  - 110 PCC <= {Nc, Zc, 0, PCC.C} (move semantics)
  - 111 PCC <= {Nc, Zc, Vc, PCC.C} (C preserved)
- Latency: outputs reflect the update one edge after the op is presented; no forwarding.
- cyin_h equals registered UCC.C.
- stall_h = 1: UCC, PCC and the trap request hold. A trap_ack_h is still honoured.
- Trap request:
  - Set when PCC.V is written with 1 by op 011, 101 or 111 while iv_en_h = 1.
  - Cleared by trap_ack_h.
  - If set and ack occur on the same edge, set wins (request stays 1).
  - A write of V = 1 while the request is already pending leaves it 1; there is no counting.
  - iv_en_h dropping does not clear a pending request.
- Illegal or unused encodings: none; all 8 ops are defined.

Test Plan:
- Reset, then op 011 with long size, wbus_h = 80000000, wmuxz_h = 0111, aluv_h = 1000, cout_h = 1000, iv_en_h = 0 -> after 1 edge ucc_h = pcc_h = 1011, ovf_trap_h = 0.
- Byte size with wbus_h = 000000FF, wmuxz_h = 1110, aluv_h = 0, cout_h = 0001, c_inv_h = 1, op 001 -> ucc_h = 1000; pcc_h unchanged.
- Quad Z accumulate:
  - Op 001, long, wmuxz_h = 1111 -> UCC.Z = 1.
  - Next op 001 with zacc_h = 1, wmuxz_h = 1110 -> UCC.Z = 0.
  - Repeat from a Z = 0 start with an all-zero second half -> Z remains 0.
- Overflow trap:
  - iv_en_h = 1, op 111, word size, aluv_h = 0010 -> ovf_trap_h = 1 next edge.
  - Hold ack low 3 cycles -> stays 1.
  - trap_ack_h = 1 -> 0.
  - Ack coincident with a new V = 1 write -> remains 1.
- Op 101 with wbus_h[3:0] = 0101 -> pcc_h = 0101. Then op 110 with Nc = 1, Zc = 0 -> pcc_h = 1001 (V cleared, C kept).
- stall_h = 1 with op 011 and changing inputs for 2 cycles -> outputs frozen. Assert rst_h while stalled -> all outputs 0 next edge.
